// File: rtl/alu_operand_collector.sv
// Operand collector in front of the ALU: gathers A/B beats that may arrive on
// different cycles and issues one registered, one-cycle request with CE=1.
module alu_operand_collector #(
   parameter int N       = 8,
   parameter int M       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [1:0]   IN_VALID,
   input  logic [M-1:0] IN_CMD,
   input  logic         IN_MODE,
   input  logic         IN_CIN,
   input  logic [N-1:0] IN_OPA,
   input  logic [N-1:0] IN_OPB,
   output logic         IN_READY,
   output logic [1:0]   INP_VALID,
   output logic         CE,
   output logic [M-1:0] CMD,
   output logic         MODE,
   output logic         CIN,
   output logic [N-1:0] OPA,
   output logic [N-1:0] OPB,
   output logic         TIMEOUT_ERR
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

   state_t         state_q, state_d;
   logic [M-1:0]   cmd_h_q, cmd_h_d;
   logic           mode_h_q, mode_h_d;
   logic           cin_h_q, cin_h_d;
   logic [N-1:0]   opa_h_q, opa_h_d;
   logic [N-1:0]   opb_h_q, opb_h_d;
   logic [1:0]     have_q, have_d;
   logic [1:0]     need_q, need_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           in_ready_q, in_ready_d;
   logic [1:0]     inp_valid_q, inp_valid_d;
   logic           ce_q, ce_d;
   logic [M-1:0]   cmd_q, cmd_d;
   logic           mode_q, mode_d;
   logic           cin_q, cin_d;
   logic [N-1:0]   opa_q, opa_d;
   logic [N-1:0]   opb_q, opb_d;
   logic           terr_q, terr_d;

   logic           issue;
   logic           timed_out;

   // Operand mask each command consumes; unknown commands ask for both.
   function automatic logic [1:0] need_of(input logic [M-1:0] cmd, input logic mode);
      logic [1:0] n;
      n = 2'b11;
      if (mode) begin
         case (cmd)
            M'(4), M'(5): n = 2'b01;
            M'(6), M'(7): n = 2'b10;
            default:      n = 2'b11;
         endcase
      end else begin
         case (cmd)
            M'(6), M'(8), M'(9):   n = 2'b01;
            M'(7), M'(10), M'(11): n = 2'b10;
            default:               n = 2'b11;
         endcase
      end
      return n;
   endfunction

   always_comb begin
      state_d     = state_q;
      cmd_h_d     = cmd_h_q;
      mode_h_d    = mode_h_q;
      cin_h_d     = cin_h_q;
      opa_h_d     = opa_h_q;
      opb_h_d     = opb_h_q;
      have_d      = have_q;
      need_d      = need_q;
      cnt_d       = cnt_q;
      in_ready_d  = 1'b1;
      inp_valid_d = 2'b00;
      ce_d        = 1'b0;
      terr_d      = 1'b0;
      cmd_d       = cmd_q;
      mode_d      = mode_q;
      cin_d       = cin_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      issue       = 1'b0;
      timed_out   = 1'b0;

      case (state_q)
         IDLE: begin
            if (IN_VALID != 2'b00) begin
               cmd_h_d  = IN_CMD;
               mode_h_d = IN_MODE;
               cin_h_d  = IN_CIN;
               need_d   = need_of(IN_CMD, IN_MODE);
               have_d   = IN_VALID;
               opa_h_d  = IN_VALID[0] ? IN_OPA : '0;
               opb_h_d  = IN_VALID[1] ? IN_OPB : '0;
               if ((have_d & need_d) == need_d) begin
                  issue = 1'b1;
               end else begin
                  state_d = COLLECT;
                  cnt_d   = CW'(1);
               end
            end
         end
         COLLECT: begin
            if (IN_VALID[0]) opa_h_d = IN_OPA;
            if (IN_VALID[1]) opb_h_d = IN_OPB;
            have_d = have_q | IN_VALID;
            if ((have_d & need_q) == need_q) begin
               issue = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               issue     = 1'b1;
               timed_out = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ISSUE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Output registers load on the edge that enters ISSUE so CE lasts exactly that state.
      if (issue) begin
         state_d     = ISSUE;
         in_ready_d  = 1'b0;
         ce_d        = 1'b1;
         inp_valid_d = have_d;
         terr_d      = timed_out;
         cmd_d       = cmd_h_d;
         mode_d      = mode_h_d;
         cin_d       = cin_h_d;
         opa_d       = have_d[0] ? opa_h_d : '0;
         opb_d       = have_d[1] ? opb_h_d : '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         cmd_h_q     <= '0;
         mode_h_q    <= 1'b0;
         cin_h_q     <= 1'b0;
         opa_h_q     <= '0;
         opb_h_q     <= '0;
         have_q      <= 2'b00;
         need_q      <= 2'b00;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         inp_valid_q <= 2'b00;
         ce_q        <= 1'b0;
         cmd_q       <= '0;
         mode_q      <= 1'b0;
         cin_q       <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         terr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_h_q     <= cmd_h_d;
         mode_h_q    <= mode_h_d;
         cin_h_q     <= cin_h_d;
         opa_h_q     <= opa_h_d;
         opb_h_q     <= opb_h_d;
         have_q      <= have_d;
         need_q      <= need_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         inp_valid_q <= inp_valid_d;
         ce_q        <= ce_d;
         cmd_q       <= cmd_d;
         mode_q      <= mode_d;
         cin_q       <= cin_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         terr_q      <= terr_d;
      end
   end

   assign IN_READY    = in_ready_q;
   assign INP_VALID   = inp_valid_q;
   assign CE          = ce_q;
   assign CMD         = cmd_q;
   assign MODE        = mode_q;
   assign CIN         = cin_q;
   assign OPA         = opa_q;
   assign OPB         = opb_q;
   assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: directed beats push expected
// requests; a negedge monitor pops one per CE pulse and checks every field.
module tb_alu_operand_collector;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] IN_VALID;
   logic [3:0] IN_CMD;
   logic       IN_MODE;
   logic       IN_CIN;
   logic [7:0] IN_OPA;
   logic [7:0] IN_OPB;
   logic       IN_READY;
   logic [1:0] INP_VALID;
   logic       CE;
   logic [3:0] CMD;
   logic       MODE;
   logic       CIN;
   logic [7:0] OPA;
   logic [7:0] OPB;
   logic       TIMEOUT_ERR;

   alu_operand_collector #(.N(8), .M(4), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_CMD(IN_CMD), .IN_MODE(IN_MODE),
      .IN_CIN(IN_CIN), .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_READY(IN_READY),
      .INP_VALID(INP_VALID), .CE(CE), .CMD(CMD), .MODE(MODE), .CIN(CIN),
      .OPA(OPA), .OPB(OPB), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic [1:0] vld;
      logic [3:0] cmd;
      logic       mode;
      logic       cin;
      logic [7:0] a;
      logic [7:0] b;
      logic       terr;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic beat(input logic [1:0] v, input logic [3:0] c, input logic md, input logic ci,
                       input logic [7:0] a, input logic [7:0] b);
      IN_VALID = v; IN_CMD = c; IN_MODE = md; IN_CIN = ci; IN_OPA = a; IN_OPB = b;
      tick();
      IN_VALID = 2'b00;
   endtask

   task automatic push(input int lat, input logic [1:0] v, input logic [3:0] c, input logic md,
                       input logic ci, input logic [7:0] a, input logic [7:0] b, input logic te);
      exp_t e;
      e.cyc = cyc + lat; e.vld = v; e.cmd = c; e.mode = md; e.cin = ci;
      e.a = a; e.b = b; e.terr = te;
      q.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ce"}, CE, 0);
      chk({tag, "_in_ready"}, IN_READY, 1);
      chk({tag, "_inp_valid"}, INP_VALID, 0);
      chk({tag, "_opa"}, OPA, 0);
      chk({tag, "_opb"}, OPB, 0);
      chk({tag, "_cmd"}, {MODE, CIN, CMD}, 0);
      chk({tag, "_terr"}, TIMEOUT_ERR, 0);
   endtask

   // Monitor: every CE pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!RST) begin
         if (CE) begin
            chk("ready_low_in_issue", IN_READY, 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ce actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("issue_cycle", cyc, e.cyc);
               chk("inp_valid", INP_VALID, e.vld);
               chk("cmd", CMD, e.cmd);
               chk("mode", MODE, e.mode);
               chk("cin", CIN, e.cin);
               chk("opa", OPA, e.a);
               chk("opb", OPB, e.b);
               chk("timeout_err", TIMEOUT_ERR, e.terr);
            end
         end else begin
            chk("idle_ready", IN_READY, 1);
            chk("idle_inp_valid", INP_VALID, 0);
            chk("idle_terr", TIMEOUT_ERR, 0);
         end
      end
   end

   initial begin
      RST = 1'b1; IN_VALID = 2'b00; IN_CMD = 4'h0; IN_MODE = 1'b0; IN_CIN = 1'b0;
      IN_OPA = 8'h00; IN_OPB = 8'h00;
      tick(); tick();
      chk_reset_outputs("reset");
      RST = 1'b0;
      tick();

      // Two beats on consecutive cycles; second beat's CMD/MODE are ignored.
      beat(2'b01, 4'd0, 1'b1, 1'b0, 8'h12, 8'h00);
      push(1, 2'b11, 4'd0, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
      beat(2'b10, 4'd5, 1'b0, 1'b1, 8'hEE, 8'h34);
      tick(); tick();

      // Single beat carrying both operands, then a beat offered during ISSUE.
      push(1, 2'b11, 4'd4, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0);
      beat(2'b11, 4'd4, 1'b0, 1'b0, 8'hF0, 8'h0F);
      beat(2'b01, 4'd9, 1'b0, 1'b0, 8'h99, 8'h00);
      tick(); tick(); tick();

      // INC_B needs only B; OPA lane must come out zero.
      push(1, 2'b10, 4'd6, 1'b1, 1'b1, 8'h00, 8'h7F, 1'b0);
      beat(2'b10, 4'd6, 1'b1, 1'b1, 8'h33, 8'h7F);
      tick(); tick();

      // Logical CMD 8 needs only A.
      push(1, 2'b01, 4'd8, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0);
      beat(2'b01, 4'd8, 1'b0, 1'b0, 8'h3C, 8'hFF);
      tick(); tick();

      // Timeout: B never arrives; forced issue 16 cycles after the first beat.
      push(16, 2'b01, 4'd1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1);
      beat(2'b01, 4'd1, 1'b1, 1'b0, 8'h05, 8'hAA);
      repeat (20) tick();

      // B arrives on the last counted cycle: completion wins over timeout.
      beat(2'b01, 4'd0, 1'b1, 1'b0, 8'h21, 8'h00);
      repeat (14) tick();
      push(1, 2'b11, 4'd0, 1'b1, 1'b0, 8'h21, 8'h43, 1'b0);
      beat(2'b10, 4'd0, 1'b1, 1'b0, 8'h00, 8'h43);
      tick(); tick(); tick();

      // Resent A overwrites the held value.
      beat(2'b01, 4'd2, 1'b1, 1'b1, 8'h55, 8'h00);
      beat(2'b01, 4'd2, 1'b1, 1'b1, 8'hAA, 8'h00);
      push(1, 2'b11, 4'd2, 1'b1, 1'b1, 8'hAA, 8'h66, 1'b0);
      beat(2'b10, 4'd2, 1'b1, 1'b1, 8'h00, 8'h66);
      tick(); tick();

      // Asynchronous reset mid-COLLECT discards the partial request.
      beat(2'b01, 4'd0, 1'b1, 1'b0, 8'h77, 8'h00);
      tick();
      #2 RST = 1'b1;
      #1 chk_reset_outputs("midreset");
      #2 RST = 1'b0;
      repeat (25) tick();

      chk("outstanding_requests", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
